cubehash_seq_ctrl: RTL and testbench

- Sequencer for the one-round-per-cycle CubeHash datapath (r=16, b=32, h=256).
- Accepts 256-bit message blocks over a valid/ready handshake and holds each block in a register.
- Drives the datapath controls: block/IV injection, state freeze, finalization XOR and hash capture.
- Counts rounds: R per block and F*R at finalization. Sits between the block receiver and the round datapath.

---
 rtl/cubehash_pkg.sv | 19 +
 rtl/cubehash_round_cnt.sv | 29 ++
 rtl/cubehash_seq_ctrl.sv | 119 +++++++++++
 tb/tb_cubehash_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cubehash_pkg.sv
// Shared constants for the CubeHash16/32-256 sequencer: round counts, widths
// and the controller state encoding.
package cubehash_pkg;
  localparam int ROUNDS     = 16;
  localparam int FIN_MULT   = 10;
  localparam int FIN_ROUNDS = FIN_MULT * ROUNDS;
  localparam int BLK_W      = 256;
  localparam int CNT_W      = $clog2(FIN_ROUNDS + 1);

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;
endpackage

// File: rtl/cubehash_round_cnt.sv
// Round down-counter: loadable, decrements when enabled, saturates at zero.
module cubehash_round_cnt #(
  parameter int CNT_W   = 8,
  parameter int MAX_VAL = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one,
  output logic             is_max
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign is_one = (cnt_q == CNT_W'(1));
  assign is_max = (cnt_q == CNT_W'(MAX_VAL));
endmodule

// File: rtl/cubehash_seq_ctrl.sv
// CubeHash sequencer: block handshake/register, round FSM and Moore-decoded
// datapath controls, all frozen while pause is high.
module cubehash_seq_ctrl #(
  parameter int ROUNDS   = cubehash_pkg::ROUNDS,
  parameter int FIN_MULT = cubehash_pkg::FIN_MULT,
  parameter int BLK_W    = cubehash_pkg::BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic [BLK_W-1:0] block,
  output logic             done,
  output logic             start1,
  output logic             in_en,
  output logic             stop_process,
  output logic             xor_fin,
  output logic             out_en,
  output logic             busy
);
  import cubehash_pkg::*;

  localparam int FIN_CYC  = FIN_MULT * ROUNDS;
  localparam int CNT_BITS = $clog2(FIN_CYC + 1);

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               last_q, last_d;
  logic               cnt_load, cnt_dec, cnt_one, cnt_max;
  logic [CNT_BITS-1:0] cnt_val;
  logic               is_idle, is_load, is_wait, is_fin, is_out, accept;

  assign is_idle = (state_q == S_IDLE);
  assign is_load = (state_q == S_LOAD);
  assign is_wait = (state_q == S_WAIT);
  assign is_fin  = (state_q == S_FIN);
  assign is_out  = (state_q == S_OUT);

  // Ready depends only on state and pause, so valid never reaches a control.
  assign blk_ready = (is_idle | is_wait) & ~pause;
  assign accept    = blk_valid & blk_ready;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (!pause) begin
      case (state_q)
        S_IDLE, S_WAIT: if (accept) state_d = S_LOAD;
        S_LOAD: begin
          cnt_load = 1'b1;
          cnt_val  = CNT_BITS'(ROUNDS - 1);
          state_d  = S_ROUND;
        end
        S_ROUND: begin
          cnt_dec = 1'b1;
          if (cnt_one) state_d = last_q ? S_TAIL : S_WAIT;
        end
        // TAIL applies the last block's final round; the count covers FIN only.
        S_TAIL: begin
          cnt_load = 1'b1;
          cnt_val  = CNT_BITS'(FIN_CYC);
          state_d  = S_FIN;
        end
        S_FIN: begin
          cnt_dec = 1'b1;
          if (cnt_one) state_d = S_OUT;
        end
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    block_d = block_q;
    last_d  = last_q;
    if (accept) begin
      block_d = blk_data;
      last_d  = blk_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      block_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      last_q  <= last_d;
    end
  end

  cubehash_round_cnt #(.CNT_W(CNT_BITS), .MAX_VAL(FIN_CYC)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .is_one   (cnt_one),
    .is_max   (cnt_max)
  );

  // WAIT drops in_en so the datapath's IV select survives only into the first LOAD.
  assign block        = block_q;
  assign done         = is_load & ~pause;
  assign start1       = is_idle;
  assign in_en        = is_idle | is_load;
  assign stop_process = pause | is_idle | is_wait | is_out;
  assign xor_fin      = is_fin & cnt_max & ~pause;
  assign out_en       = is_out & ~pause;
  assign busy         = ~is_idle;
endmodule

// File: tb/tb_cubehash_seq_ctrl.sv
// Bench for cubehash_seq_ctrl: timeline model of the controls, plus a
// behavioural datapath whose captured hash is scored against plain CubeHash.
module tb_cubehash_seq_ctrl;
  localparam int R   = 16;
  localparam int FR  = 160;
  localparam int OUTP = R + 2 + FR;   // position of OUT after an accept
  typedef logic [31:0][31:0] st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_dir = 1'b0, pause_rnd = 1'b0, pause;
  logic blk_valid = 1'b0, blk_last = 1'b0;
  logic [255:0] blk_data = '0;
  logic blk_ready, done, start1, in_en, stop_process, xor_fin, out_en, busy;
  logic [255:0] block;
  bit rnd_en = 1'b0;

  assign pause = pause_dir | pause_rnd;
  always #5 clk = ~clk;

  cubehash_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .blk_valid(blk_valid),
    .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready),
    .block(block), .done(done), .start1(start1), .in_en(in_en),
    .stop_process(stop_process), .xor_fin(xor_fin), .out_en(out_en), .busy(busy)
  );

  int checks = 0, errors = 0;
  st_t iv_st, dp_s, ref_s;
  logic dp_start;
  logic [255:0] blk_q[$], hash_q[$];
  bit m_busy = 0, m_last = 0;
  int m_pos = 0;
  logic [255:0] m_blk = '0;

  function automatic st_t ch_round(input st_t xi);
    st_t x; logic [31:0] t;
    x = xi;
    for (int i = 0; i < 16; i++) x[i+16] = x[i+16] + x[i];
    for (int i = 0; i < 16; i++) x[i] = {x[i][24:0], x[i][31:25]};
    for (int i = 0; i < 8; i++) begin t = x[i]; x[i] = x[i+8]; x[i+8] = t; end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
    for (int i = 16; i < 32; i++) if ((i & 2) == 0) begin t = x[i]; x[i] = x[i+2]; x[i+2] = t; end
    for (int i = 0; i < 16; i++) x[i+16] = x[i+16] + x[i];
    for (int i = 0; i < 16; i++) x[i] = {x[i][20:0], x[i][31:21]};
    for (int i = 0; i < 16; i++) if ((i & 4) == 0) begin t = x[i]; x[i] = x[i+4]; x[i+4] = t; end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
    for (int i = 16; i < 32; i += 2) begin t = x[i]; x[i] = x[i+1]; x[i+1] = t; end
    return x;
  endfunction

  function automatic st_t ch_rounds(input st_t xi, input int n);
    st_t x;
    x = xi;
    for (int k = 0; k < n; k++) x = ch_round(x);
    return x;
  endfunction

  function automatic st_t xor_blk(input st_t s, input logic [255:0] b);
    st_t x;
    x = s;
    for (int i = 0; i < 8; i++) x[i] = x[i] ^ b[32*i +: 32];
    return x;
  endfunction

  function automatic st_t fin_x(input st_t s);
    st_t x;
    x = s;
    x[31] = x[31] ^ 32'd1;
    return x;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Expected controls from the position (in non-paused cycles) since the last accept.
  function automatic logic [7:0] exp_ctrl(input bit bz, input bit lst, input int pos, input logic p);
    bit idle, load, wt, fin1, outp;
    idle = !bz;
    load = bz && pos == 1;
    wt   = bz && !lst && pos == R + 1;
    fin1 = bz && lst && pos == R + 2;
    outp = bz && lst && pos == OUTP;
    return {(idle || wt) && !p, load && !p, idle, idle || load,
            p || idle || wt || outp, fin1 && !p, outp && !p, bz};
  endfunction

  // Datapath stand-in driven purely by the controller outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s     <= '0;
      dp_start <= 1'b1;
    end else begin
      if (in_en && (start1 || done)) dp_start <= start1;
      if (!stop_process) begin
        if (done)         dp_s <= xor_blk(dp_start ? iv_st : ch_round(dp_s), block);
        else if (xor_fin) dp_s <= ch_round(fin_x(dp_s));
        else              dp_s <= ch_round(dp_s);
      end
    end
  end

  // Reference model: per-cycle control check, then advance and push expectations.
  always @(negedge clk) begin
    logic [7:0] act, exv;
    bit wt;
    if (!rst_n) begin
      m_busy = 0; m_last = 0; m_pos = 0; m_blk = '0;
      blk_q.delete(); hash_q.delete();
    end
    act = {blk_ready, done, start1, in_en, stop_process, xor_fin, out_en, busy};
    exv = exp_ctrl(m_busy, m_last, m_pos, pause);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL ctrl t=%0t pos=%0d actual=%b required=%b (rdy,done,st1,in_en,stop,xfin,out,busy)",
               $time, m_pos, act, exv);
    end
    checks++;
    if (block !== m_blk) begin
      errors++;
      $display("FAIL block_hold t=%0t actual=%h required=%h", $time, block, m_blk);
    end
    if (rst_n && !pause) begin
      wt = m_busy && !m_last && m_pos == R + 1;
      if ((!m_busy || wt) && blk_valid) begin
        ref_s = xor_blk(m_busy ? ref_s : iv_st, blk_data);
        ref_s = ch_rounds(ref_s, R);
        if (blk_last) hash_q.push_back(ch_rounds(fin_x(ref_s), FR)[7:0]);
        blk_q.push_back(blk_data);
        m_busy = 1; m_pos = 1; m_last = blk_last; m_blk = blk_data;
      end else if (m_busy && m_last && m_pos == OUTP) begin
        m_busy = 0;
      end else if (m_busy && !wt) begin
        m_pos++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    logic [255:0] e;
    if (rst_n && done) begin
      checks++;
      if (blk_q.size() == 0) begin
        errors++; $display("FAIL done_unexpected t=%0t actual=1 required=0", $time);
      end else begin
        e = blk_q.pop_front();
        if (block !== e) begin
          errors++; $display("FAIL done_block t=%0t actual=%h required=%h", $time, block, e);
        end
      end
    end
    if (rst_n && out_en) begin
      checks++;
      if (hash_q.size() == 0) begin
        errors++; $display("FAIL out_unexpected t=%0t actual=1 required=0", $time);
      end else begin
        e = hash_q.pop_front();
        if (dp_s[7:0] !== e) begin
          errors++; $display("FAIL hash t=%0t actual=%h required=%h", $time, dp_s[7:0], e);
        end
      end
    end
  end

  task automatic send_blk(input logic [255:0] d, input logic l);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    blk_valid = 1'b1; blk_data = d; blk_last = l;
    while (!acc && n < 3000) begin
      @(negedge clk); acc = blk_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL handshake_timeout actual=no_accept required=accept");
    end
    blk_valid = 1'b0; blk_data = rnd256(); blk_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    pause_rnd = rnd_en && ($urandom_range(0, 7) == 0);
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    st_t x;
    int nb;
    x = '0; x[0] = 32'd32; x[1] = 32'd32; x[2] = 32'd16;
    iv_st = ch_rounds(x, FR);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single all-zero block through the real-datapath stand-in
    send_blk('0, 1'b1);
    wait_idle();

    // two blocks; second held valid through the first block's rounds
    send_blk(rnd256(), 1'b0);
    send_blk(rnd256(), 1'b1);
    wait_idle();

    // pause for 5 cycles starting at the first FIN cycle
    send_blk(rnd256(), 1'b1);
    repeat (17) @(posedge clk);
    #1 pause_dir = 1'b1;
    repeat (5) @(posedge clk);
    #1 pause_dir = 1'b0;
    wait_idle();

    // reset in the middle of ROUND, then a fresh message
    send_blk(rnd256(), 1'b1);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_blk(rnd256(), 1'b1);
    wait_idle();

    // random messages under random pause
    rnd_en = 1'b1;
    for (int m = 0; m < 25; m++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) send_blk(rnd256(), 1'(b == nb - 1));
      wait_idle();
    end
    rnd_en = 1'b0;
    repeat (5) @(posedge clk);

    checks++;
    if (blk_q.size() != 0 || hash_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", blk_q.size(), hash_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
